// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bus: pipeline register indices and status in, stall/flush/forward controls out.
interface pipeline_hazard_ctrl_if;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic [4:0] rs1_EX;
  logic [4:0] rs2_EX;
  logic [4:0] rd_EX;
  logic       MemRead_EX;
  logic [4:0] rd_MEM;
  logic       RegWrite_MEM;
  logic [4:0] rd_WB;
  logic       RegWrite_WB;
  logic       branch_taken_EX;
  logic       mem_busy;
  logic       PCWrite;
  logic       IFIDWrite;
  logic       IDEX_bubble;
  logic       IFID_flush;
  logic       pipe_hold;
  logic [1:0] forwardA;
  logic [1:0] forwardB;
  logic       mem_timeout;

  modport master (
    output rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, MemRead_EX, rd_MEM, RegWrite_MEM,
           rd_WB, RegWrite_WB, branch_taken_EX, mem_busy,
    input  PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, pipe_hold, forwardA, forwardB,
           mem_timeout
  );

  modport slave (
    input  rs1_ID, rs2_ID, rs1_EX, rs2_EX, rd_EX, MemRead_EX, rd_MEM, RegWrite_MEM,
           rd_WB, RegWrite_WB, branch_taken_EX, mem_busy,
    output PCWrite, IFIDWrite, IDEX_bubble, IFID_flush, pipe_hold, forwardA, forwardB,
           mem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forward scheduler for the 5-stage RV32 pipeline with a memory-wait watchdog.
// Optional HAZARD_PERF_EN adds stall_cnt/flush_cnt performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           stall_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int unsigned PERF_W = 32;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             load_use;

  assign load_use = hz.MemRead_EX && (hz.rd_EX != 5'd0) &&
                    ((hz.rd_EX == hz.rs1_ID) || (hz.rd_EX == hz.rs2_ID));

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state and watchdog counter
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (hz.mem_busy) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = CNT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!hz.mem_busy) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Pipeline controls; a released wait falls straight into run priority in the same cycle
  always_comb begin
    hz.PCWrite     = 1'b1;
    hz.IFIDWrite   = 1'b1;
    hz.IDEX_bubble = 1'b0;
    hz.IFID_flush  = 1'b0;
    hz.pipe_hold   = 1'b0;
    hz.mem_timeout = 1'b0;
    if (state_q == ST_ERROR) begin
      hz.PCWrite     = 1'b0;
      hz.IFIDWrite   = 1'b0;
      hz.pipe_hold   = 1'b1;
      hz.mem_timeout = 1'b1;
    end else if (hz.mem_busy) begin
      hz.PCWrite   = 1'b0;
      hz.IFIDWrite = 1'b0;
      hz.pipe_hold = 1'b1;
    end else if (hz.branch_taken_EX) begin
      hz.IFID_flush  = 1'b1;
      hz.IDEX_bubble = 1'b1;
    end else if (load_use) begin
      hz.PCWrite     = 1'b0;
      hz.IFIDWrite   = 1'b0;
      hz.IDEX_bubble = 1'b1;
    end
  end

  // EX operand forwarding; MEM is younger so it wins over WB, x0 never forwards
  always_comb begin
    hz.forwardA = 2'b00;
    hz.forwardB = 2'b00;
    if (hz.RegWrite_MEM && (hz.rd_MEM != 5'd0) && (hz.rd_MEM == hz.rs1_EX))
      hz.forwardA = 2'b10;
    else if (hz.RegWrite_WB && (hz.rd_WB != 5'd0) && (hz.rd_WB == hz.rs1_EX))
      hz.forwardA = 2'b01;
    if (hz.RegWrite_MEM && (hz.rd_MEM != 5'd0) && (hz.rd_MEM == hz.rs2_EX))
      hz.forwardB = 2'b10;
    else if (hz.RegWrite_WB && (hz.rd_WB != 5'd0) && (hz.rd_WB == hz.rs2_EX))
      hz.forwardB = 2'b01;
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!hz.PCWrite)   stall_cnt <= stall_cnt + PERF_W'(1);
      if (hz.IFID_flush) flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule
